// File: rtl/satd_engine.sv
// Sequential SATD engine: row differences + horizontal Hadamard into a transpose buffer,
// then column-wise vertical Hadamard with |coef| accumulation. Define SATD_NORM_EN for HEVC scaling.
module satd_engine #(
    parameter int LENGTH = 11,
    parameter int WIDTH  = 8,
    parameter int LOG2W  = 3,
    parameter int SATD_W = LENGTH + 2 + 4 * LOG2W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(LENGTH+1)*WIDTH-1:0] ORG,
    input  logic [(LENGTH+1)*WIDTH-1:0] CUR,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SATD_W-1:0]           satd
);
    localparam int SW = LENGTH + 1;
    localparam int HW = LENGTH + 2 + LOG2W;
    localparam int VW = HW + LOG2W;
    localparam logic [LOG2W-1:0] LAST = LOG2W'(WIDTH - 1);

    typedef enum logic [1:0] {S_LOAD, S_VERT, S_DONE} state_t;

    state_t             r_state;
    logic [LOG2W-1:0]   r_row_cnt;
    logic [LOG2W-1:0]   r_col_cnt;
    logic [SATD_W-1:0]  r_acc;
    logic [SATD_W-1:0]  r_satd;
    logic               r_out_valid;
    logic signed [HW-1:0] r_buf [WIDTH][WIDTH];

    logic signed [HW-1:0] w_h [LOG2W+1][WIDTH];
    logic signed [VW-1:0] w_v [LOG2W+1][WIDTH];
    logic [SATD_W-1:0]    w_colsum;
    logic [SATD_W-1:0]    w_acc_next;
    logic [SATD_W-1:0]    w_norm;

    // Unnormalised fast Walsh-Hadamard butterflies, span doubling each stage
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            w_h[0][i] = HW'($signed(ORG[i*SW +: SW])) - HW'($signed(CUR[i*SW +: SW]));
        for (int s = 0; s < LOG2W; s++)
            for (int j = 0; j < WIDTH; j++)
                if ((j & (1 << s)) == 0)
                    w_h[s+1][j] = w_h[s][j] + w_h[s][j + (1 << s)];
                else
                    w_h[s+1][j] = w_h[s][j - (1 << s)] - w_h[s][j];
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            w_v[0][i] = VW'(r_buf[i][r_col_cnt]);
        for (int s = 0; s < LOG2W; s++)
            for (int j = 0; j < WIDTH; j++)
                if ((j & (1 << s)) == 0)
                    w_v[s+1][j] = w_v[s][j] + w_v[s][j + (1 << s)];
                else
                    w_v[s+1][j] = w_v[s][j - (1 << s)] - w_v[s][j];
        w_colsum = '0;
        for (int j = 0; j < WIDTH; j++)
            if (w_v[LOG2W][j][VW-1])
                w_colsum = w_colsum + SATD_W'($unsigned(-w_v[LOG2W][j]));
            else
                w_colsum = w_colsum + SATD_W'($unsigned(w_v[LOG2W][j]));
    end

    assign w_acc_next = r_acc + w_colsum;

`ifdef SATD_NORM_EN
    localparam int NSH = (WIDTH == 8) ? 2 : 1;
    assign w_norm = (w_acc_next + SATD_W'(1 << (NSH - 1))) >> NSH;
`else
    assign w_norm = w_acc_next;
`endif

    // Buffer contents after reset or flush are never read before being rewritten
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid && !flush)
            for (int j = 0; j < WIDTH; j++)
                r_buf[r_row_cnt][j] <= w_h[LOG2W][j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_acc       <= '0;
            r_satd      <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_LOAD;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (r_row_cnt == LAST) begin
                            r_state   <= S_VERT;
                            r_col_cnt <= '0;
                            r_acc     <= '0;
                        end
                    end
                end
                S_VERT: begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                    r_acc     <= w_acc_next;
                    if (r_col_cnt == LAST) begin
                        r_state     <= S_DONE;
                        r_satd      <= w_norm;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_LOAD;
                        r_row_cnt   <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = r_out_valid;
    assign satd      = r_satd;
endmodule
